event_timestamp_fifo: RTL and testbench



---
 rtl/event_timestamp_fifo.sv | 156 +++++++++++++++
 tb/tb_event_timestamp_fifo.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/event_timestamp_fifo.sv
// Event timestamper: stamps accepted event pulses with a free-running counter, applies a
// holdoff dead time and buffers stamps in a FIFO. Define EVENT_TS_DROP_COUNT_EN for drop_count.
module event_timestamp_fifo #(
  parameter int TS_WIDTH = 32,
  parameter int DEPTH    = 16,
  parameter int HOLDOFF  = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ev_pulse,
  input  logic                   enable,
  input  logic                   ts_clear,
  input  logic                   rd_en,
  output logic [TS_WIDTH-1:0]    rd_data,
  output logic                   rd_valid,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   overflow_clr
`ifdef EVENT_TS_DROP_COUNT_EN
  ,
  output logic [15:0]            drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HW-1:0] HOLD_INIT = (HOLDOFF > 0) ? HW'(HOLDOFF - 1) : '0;
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t               state_q, state_d;
  logic [HW-1:0]        hcnt_q, hcnt_d;
  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic [TS_WIDTH-1:0]  mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q, count_d;
  logic                 empty_q, full_q, overflow_q, overflow_d;
  logic [TS_WIDTH-1:0]  rd_data_q;
  logic                 rd_valid_q;
  logic                 accept, pop, push, lost_full;

  // Timestamp counter: clear beats enable; the stamp uses the pre-edge value.
  always_comb begin
    ts_d = ts_q;
    if (ts_clear)    ts_d = '0;
    else if (enable) ts_d = ts_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ev_pulse && enable) begin
          accept = 1'b1;
          if (HOLDOFF != 0) begin
            state_d = HOLD;
            hcnt_d  = HOLD_INIT;
          end
        end
      end
      HOLD: begin
        if (hcnt_q == '0) state_d = IDLE;
        else              hcnt_d  = hcnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop       = rd_en && !empty_q;
  assign push      = accept && (!full_q || pop);
  assign lost_full = accept && full_q && !pop;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A fresh loss wins over a same-cycle clear.
  always_comb begin
    overflow_d = overflow_q;
    if (lost_full)         overflow_d = 1'b1;
    else if (overflow_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      hcnt_q     <= '0;
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      ts_q       <= ts_d;
      count_q    <= count_d;
      empty_q    <= (count_d == '0);
      full_q     <= (count_d == FULL_CNT);
      overflow_q <= overflow_d;
      rd_valid_q <= pop;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        rd_data_q <= mem_q[rd_ptr_q];
      end
    end
  end

  // Storage array kept reset-free; when full, a same-cycle pop reads the old entry first.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ts_q;
  end

`ifdef EVENT_TS_DROP_COUNT_EN
  logic [15:0] drop_q, drop_d;
  logic        lost;

  assign lost = lost_full || (ev_pulse && enable && (state_q == HOLD));

  always_comb begin
    drop_d = drop_q;
    if (overflow_clr)                  drop_d = lost ? 16'd1 : 16'd0;
    else if (lost && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) drop_q <= '0;
    else          drop_q <= drop_d;
  end

  assign drop_count = drop_q;
`endif

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_event_timestamp_fifo.sv
// Bench for event_timestamp_fifo: two instances (32-bit/holdoff 8 and 8-bit/holdoff 0) share stimulus
// and are checked every cycle against a cycle-count based reference model.
module tb_event_timestamp_fifo;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic ev_pulse = 1'b0, enable = 1'b0, ts_clear = 1'b0, rd_en = 1'b0, overflow_clr = 1'b0;

  logic [31:0] rd_data_a;
  logic [7:0]  rd_data_b;
  logic        rd_valid_a, rd_valid_b, empty_a, empty_b, full_a, full_b, overflow_a, overflow_b;
  logic [4:0]  count_a, count_b;
`ifdef EVENT_TS_DROP_COUNT_EN
  logic [15:0] drop_a, drop_b;
`endif

  event_timestamp_fifo #(.TS_WIDTH(32), .DEPTH(DEPTH), .HOLDOFF(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .ev_pulse(ev_pulse), .enable(enable), .ts_clear(ts_clear),
    .rd_en(rd_en), .rd_data(rd_data_a), .rd_valid(rd_valid_a), .empty(empty_a), .full(full_a),
    .count(count_a), .overflow(overflow_a), .overflow_clr(overflow_clr)
`ifdef EVENT_TS_DROP_COUNT_EN
    , .drop_count(drop_a)
`endif
  );

  event_timestamp_fifo #(.TS_WIDTH(8), .DEPTH(DEPTH), .HOLDOFF(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .ev_pulse(ev_pulse), .enable(enable), .ts_clear(ts_clear),
    .rd_en(rd_en), .rd_data(rd_data_b), .rd_valid(rd_valid_b), .empty(empty_b), .full(full_b),
    .count(count_b), .overflow(overflow_b), .overflow_clr(overflow_clr)
`ifdef EVENT_TS_DROP_COUNT_EN
    , .drop_count(drop_b)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: acceptance is decided by the cycle number of the last accepted event.
  int          cyc;
  int          next_ok [2];
  int          hold    [2] = '{8, 0};
  logic [31:0] mask    [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
  logic [31:0] m_ts    [2];
  logic [31:0] mbuf    [2][64];
  int          head    [2];
  int          tail    [2];
  logic [31:0] m_data  [2];
  logic        m_valid [2];
  logic        m_ovf   [2];
  int          m_drop  [2];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, got, exp);
  endtask

  task automatic model_reset();
    cyc = 0;
    for (int k = 0; k < 2; k++) begin
      next_ok[k] = 0; m_ts[k] = 0; head[k] = 0; tail[k] = 0;
      m_data[k] = 0; m_valid[k] = 1'b0; m_ovf[k] = 1'b0; m_drop[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int occ;
      bit pop, acc, drop, set_ovf;
      occ = tail[k] - head[k];
      pop = rd_en && (occ > 0);
      set_ovf = 1'b0;
      m_valid[k] = pop;
      if (pop) begin
        m_data[k] = mbuf[k][head[k] % 64];
        head[k]++;
      end
      acc  = ev_pulse && enable && (cyc >= next_ok[k]);
      drop = ev_pulse && enable && !acc;
      if (acc) begin
        next_ok[k] = cyc + hold[k] + 1;
        if (occ < DEPTH || pop) begin
          mbuf[k][tail[k] % 64] = m_ts[k];
          tail[k]++;
        end else begin
          set_ovf = 1'b1;
          drop = 1'b1;
        end
      end
      if (set_ovf) m_ovf[k] = 1'b1;
      else if (overflow_clr) m_ovf[k] = 1'b0;
      if (overflow_clr) m_drop[k] = drop ? 1 : 0;
      else if (drop && m_drop[k] < 65535) m_drop[k]++;
      if (ts_clear) m_ts[k] = 0;
      else if (enable) m_ts[k] = (m_ts[k] + 1) & mask[k];
    end
    cyc++;
  endtask

  task automatic compare_all();
    chk("a.rd_valid", 32'(rd_valid_a), 32'(m_valid[0]));
    chk("a.rd_data",  rd_data_a, m_data[0]);
    chk("a.count",    32'(count_a), 32'(tail[0] - head[0]));
    chk("a.empty",    32'(empty_a), 32'(tail[0] == head[0]));
    chk("a.full",     32'(full_a),  32'(tail[0] - head[0] == DEPTH));
    chk("a.overflow", 32'(overflow_a), 32'(m_ovf[0]));
    chk("b.rd_valid", 32'(rd_valid_b), 32'(m_valid[1]));
    chk("b.rd_data",  32'(rd_data_b), m_data[1]);
    chk("b.count",    32'(count_b), 32'(tail[1] - head[1]));
    chk("b.empty",    32'(empty_b), 32'(tail[1] == head[1]));
    chk("b.full",     32'(full_b),  32'(tail[1] - head[1] == DEPTH));
    chk("b.overflow", 32'(overflow_b), 32'(m_ovf[1]));
`ifdef EVENT_TS_DROP_COUNT_EN
    chk("a.drop_count", 32'(drop_a), 32'(m_drop[0]));
    chk("b.drop_count", 32'(drop_b), 32'(m_drop[1]));
`endif
  endtask

  // Inputs are set in the low phase; one call covers one rising edge.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit          ev;
    bit          rd;
    int          cnt_a;
    int          cnt_b;
    bit          val_a;
    logic [31:0] data_a;
  } vec_t;

  vec_t tbl [32];
  logic [7:0] last_b;

  initial begin
    for (int i = 0; i < 32; i++) begin
      tbl[i].ev     = (i == 10) || (i == 20) || (i == 25) || (i == 29);
      tbl[i].rd     = (i == 11);
      tbl[i].cnt_a  = (i == 10) ? 1 : (i >= 29) ? 2 : (i >= 20) ? 1 : 0;
      tbl[i].cnt_b  = (i == 10) ? 1 : (i >= 29) ? 3 : (i >= 25) ? 2 : (i >= 20) ? 1 : 0;
      tbl[i].val_a  = (i == 11);
      tbl[i].data_a = (i >= 11) ? 32'd10 : 32'd0;
    end

    #2;
    do_reset();

    // Single event read-back, then holdoff filtering of 20/25/29.
    enable = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ev_pulse = tbl[i].ev;
      rd_en    = tbl[i].rd;
      step();
      chk("tbl.count_a",  32'(count_a), 32'(tbl[i].cnt_a));
      chk("tbl.count_b",  32'(count_b), 32'(tbl[i].cnt_b));
      chk("tbl.rd_valid", 32'(rd_valid_a), 32'(tbl[i].val_a));
      chk("tbl.rd_data",  rd_data_a, tbl[i].data_a);
    end
    ev_pulse = 1'b0; rd_en = 1'b0;
`ifdef EVENT_TS_DROP_COUNT_EN
    chk("tbl.drop_a", 32'(drop_a), 32'd1);
    chk("tbl.drop_b", 32'(drop_b), 32'd0);
`endif

    // 17 back-to-back pulses: holdoff-0 instance fills and overflows.
    do_reset();
    enable = 1'b1;
    ev_pulse = 1'b1;
    for (int i = 0; i < 17; i++) step();
    ev_pulse = 1'b0;
    chk("fill.full_b",  32'(full_b), 32'd1);
    chk("fill.count_b", 32'(count_b), 32'd16);
    chk("fill.ovf_b",   32'(overflow_b), 32'd1);
    chk("fill.count_a", 32'(count_a), 32'd2);
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("drain.data_b",  32'(rd_data_b), 32'(i));
      chk("drain.valid_b", 32'(rd_valid_b), 32'd1);
    end
    rd_en = 1'b0;
    step();
    chk("drain.empty_b", 32'(empty_b), 32'd1);

    // Full FIFO with simultaneous pulse and pop.
    do_reset();
    enable = 1'b1;
    ev_pulse = 1'b1;
    for (int i = 0; i < 16; i++) step();
    rd_en = 1'b1;
    step();
    chk("fullrw.count_b", 32'(count_b), 32'd16);
    chk("fullrw.ovf_b",   32'(overflow_b), 32'd0);
    ev_pulse = 1'b0;
    for (int i = 0; i < 16; i++) step();
    last_b = rd_data_b;
    chk("fullrw.last_b", 32'(last_b), 32'd16);
    rd_en = 1'b0;

    // 8-bit wrap: stamps 255 then 0.
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 255; i++) step();
    ev_pulse = 1'b1;
    step();
    step();
    ev_pulse = 1'b0;
    rd_en = 1'b1;
    step();
    chk("wrap.first_b", 32'(rd_data_b), 32'h0000_00FF);
    step();
    chk("wrap.second_b", 32'(rd_data_b), 32'h0000_0000);
    rd_en = 1'b0;

    // Reset while holding five entries and in holdoff.
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 38; i++) begin
      ev_pulse = (i % 9 == 0) && (i <= 36);
      step();
    end
    ev_pulse = 1'b0;
    chk("midrst.count_a_before", 32'(count_a), 32'd5);
    do_reset();
    chk("midrst.count_a",  32'(count_a), 32'd0);
    chk("midrst.empty_a",  32'(empty_a), 32'd1);
    chk("midrst.rd_data_a", rd_data_a, 32'd0);
    ev_pulse = 1'b1;
    step();
    ev_pulse = 1'b0;
    chk("midrst.accept_a", 32'(count_a), 32'd1);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 999) < 2) begin
        ev_pulse = 1'b0; rd_en = 1'b0;
        do_reset();
      end
      ev_pulse     = ($urandom_range(0, 99) < 45);
      enable       = ($urandom_range(0, 99) < 85);
      ts_clear     = ($urandom_range(0, 99) < 3);
      rd_en        = ($urandom_range(0, 99) < 30);
      overflow_clr = ($urandom_range(0, 99) < 5);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
